// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM controller between the MEM data port (P0, R/W) and the fetch port (P1, read-only).
module sram_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int BUSY_TMO     = 3
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_p0_req,
  input  logic              i_p0_we,
  input  logic [ADDR_W-1:0] i_p0_addr,
  input  logic [DATA_W-1:0] i_p0_wdata,
  output logic [DATA_W-1:0] o_p0_rdata,
  output logic              o_p0_ack,
  output logic              o_p0_stall,
  input  logic              i_p1_req,
  input  logic [ADDR_W-1:0] i_p1_addr,
  output logic [DATA_W-1:0] o_p1_rdata,
  output logic              o_p1_ack,
  output logic              o_p1_stall,
  output logic              o_ctrl_re,
  output logic              o_ctrl_we,
  output logic [ADDR_W-1:0] o_ctrl_addr,
  output logic [DATA_W-1:0] o_ctrl_wdata,
  input  logic [DATA_W-1:0] i_ctrl_rdata,
  input  logic              i_ctrl_ready,
  output logic              o_err_tmo
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(BUSY_TMO + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESP} state_t;
  state_t r_state, w_next;
  logic r_gnt, r_we, r_err;
  logic [SW-1:0] r_starve;
  logic [TW-1:0] r_tmo_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_p0_rdata, r_p1_rdata;
  logic w_arb, w_p1_sel, w_tmo, w_done;
  assign w_arb    = (r_state == IDLE) & (i_p0_req | i_p1_req);
  assign w_p1_sel = i_p1_req & (~i_p0_req | (r_starve == SW'(STARVE_LIMIT)));
  assign w_tmo    = (r_state == WAIT_BUSY) & i_ctrl_ready & (r_tmo_cnt == TW'(BUSY_TMO - 1));
  assign w_done   = ((r_state == WAIT_DONE) & i_ctrl_ready) | w_tmo;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = w_arb ? ISSUE : IDLE;
      ISSUE:     w_next = WAIT_BUSY;
      WAIT_BUSY: w_next = !i_ctrl_ready ? WAIT_DONE : w_tmo ? RESP : WAIT_BUSY;
      WAIT_DONE: w_next = i_ctrl_ready ? RESP : WAIT_DONE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_gnt      <= 1'b0;
      r_we       <= 1'b0;
      r_err      <= 1'b0;
      r_starve   <= '0;
      r_tmo_cnt  <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_p0_rdata <= '0;
      r_p1_rdata <= '0;
    end else begin
      r_state   <= w_next;
      r_tmo_cnt <= (r_state == WAIT_BUSY) ? r_tmo_cnt + TW'(1) : '0;
      if (w_arb) begin
        r_gnt    <= w_p1_sel;
        r_we     <= ~w_p1_sel & i_p0_we;
        r_addr   <= w_p1_sel ? i_p1_addr : i_p0_addr;
        r_wdata  <= w_p1_sel ? '0 : i_p0_wdata;
        // counts P0 wins that left P1 waiting; any other grant resets the run
        r_starve <= (w_p1_sel | ~i_p1_req) ? '0 :
                    (r_starve == SW'(STARVE_LIMIT)) ? r_starve : r_starve + SW'(1);
      end
      if (w_done & ~r_we & ~r_gnt) r_p0_rdata <= i_ctrl_rdata;
      if (w_done & ~r_we & r_gnt) r_p1_rdata <= i_ctrl_rdata;
      if (w_tmo) r_err <= 1'b1;
    end
  end
  assign o_ctrl_re    = (r_state == ISSUE) & ~r_we;
  assign o_ctrl_we    = (r_state == ISSUE) & r_we;
  assign o_ctrl_addr  = r_addr;
  assign o_ctrl_wdata = r_wdata;
  assign o_p0_ack     = (r_state == RESP) & ~r_gnt;
  assign o_p1_ack     = (r_state == RESP) & r_gnt;
  assign o_p0_rdata   = r_p0_rdata;
  assign o_p1_rdata   = r_p1_rdata;
  assign o_p0_stall   = i_p0_req & ~o_p0_ack & ~rst;
  assign o_p1_stall   = i_p1_req & ~o_p1_ack & ~rst;
  assign o_err_tmo    = r_err;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb_sram_port_arbiter: random and directed traffic on both ports, scoreboard-checked against a reference model.
module tb_sram_port_arbiter;
  logic clk = 0, rst = 1;
  logic i_p0_req = 0, i_p0_we = 0, i_p1_req = 0, i_ctrl_ready;
  logic [31:0] i_p0_addr = 0, i_p0_wdata = 0, i_p1_addr = 0, i_ctrl_rdata;
  logic [31:0] o_p0_rdata, o_p1_rdata, o_ctrl_addr, o_ctrl_wdata;
  logic o_p0_ack, o_p0_stall, o_p1_ack, o_p1_stall, o_ctrl_re, o_ctrl_we, o_err_tmo;
  always #5 clk = ~clk;
  sram_port_arbiter dut (
    .clk(clk), .rst(rst),
    .i_p0_req(i_p0_req), .i_p0_we(i_p0_we), .i_p0_addr(i_p0_addr), .i_p0_wdata(i_p0_wdata),
    .o_p0_rdata(o_p0_rdata), .o_p0_ack(o_p0_ack), .o_p0_stall(o_p0_stall),
    .i_p1_req(i_p1_req), .i_p1_addr(i_p1_addr),
    .o_p1_rdata(o_p1_rdata), .o_p1_ack(o_p1_ack), .o_p1_stall(o_p1_stall),
    .o_ctrl_re(o_ctrl_re), .o_ctrl_we(o_ctrl_we), .o_ctrl_addr(o_ctrl_addr), .o_ctrl_wdata(o_ctrl_wdata),
    .i_ctrl_rdata(i_ctrl_rdata), .i_ctrl_ready(i_ctrl_ready), .o_err_tmo(o_err_tmo)
  );
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;
  txn_t q0[$], q1[$];
  int total = 0, bad = 0;
  logic [31:0] rmem [logic [31:0]];
  logic [31:0] cmem [logic [31:0]];
  logic [31:0] last0 = 0, last1 = 0;
  function automatic logic [31:0] init_val(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction
  function automatic logic [31:0] rd_ref(logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : init_val(a);
  endfunction
  function automatic logic [31:0] rd_ctl(logic [31:0] a);
    return cmem.exists(a) ? cmem[a] : init_val(a);
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask
  // controller model: goes busy the cycle after an enable for a few cycles, unless told to stay idle
  int busy_n = 1, busy_left = 0;
  bit rand_busy = 0, tmo_mode = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      i_ctrl_ready <= 1'b1;
      i_ctrl_rdata <= 32'h0;
      busy_left    <= 0;
    end else if (busy_left > 0) begin
      busy_left <= busy_left - 1;
      if (busy_left == 1) i_ctrl_ready <= 1'b1;
    end else if (o_ctrl_re | o_ctrl_we) begin
      if (o_ctrl_we) cmem[o_ctrl_addr] = o_ctrl_wdata;
      else i_ctrl_rdata <= rd_ctl(o_ctrl_addr);
      if (!tmo_mode) begin
        i_ctrl_ready <= 1'b0;
        busy_left    <= rand_busy ? int'($urandom_range(1, 5)) : busy_n;
      end
    end
  end
  // monitor: protocol checks every cycle, scoreboard pops on ack, grant order checked on issue
  bit pv0 = 0, pv1 = 0, prev_issue = 0;
  int starve_m = 0, n_issue = 0, p1_last_idx = 0;
  always @(negedge clk) begin
    txn_t t;
    bit issue, port, exp_port;
    if (rst) begin
      prev_issue = 0; starve_m = 0; pv0 = 0; pv1 = 0;
    end else begin
      chk("p0_stall", 32'(o_p0_stall), 32'(i_p0_req & ~o_p0_ack));
      chk("p1_stall", 32'(o_p1_stall), 32'(i_p1_req & ~o_p1_ack));
      chk("ack_overlap", 32'(o_p0_ack & o_p1_ack), 0);
      if (o_p0_ack) begin
        if (q0.size() == 0) chk("p0_ack_unexpected", 1, 0);
        else begin t = q0.pop_front(); chk("p0_rdata", o_p0_rdata, t.rdata); end
      end
      if (o_p1_ack) begin
        if (q1.size() == 0) chk("p1_ack_unexpected", 1, 0);
        else begin t = q1.pop_front(); chk("p1_rdata", o_p1_rdata, t.rdata); end
      end
      issue = o_ctrl_re | o_ctrl_we;
      if (issue) begin
        chk("re_we_excl", 32'(o_ctrl_re & o_ctrl_we), 0);
        chk("issue_pulse", 32'(prev_issue), 0);
        port = o_ctrl_addr[15];
        exp_port = (pv0 & pv1) ? (starve_m == 4) : pv1;
        chk("grant", 32'(port), 32'(exp_port));
        starve_m = (pv1 & ~exp_port) ? ((starve_m == 4) ? 4 : starve_m + 1) : 0;
        n_issue++;
        if (port) begin
          p1_last_idx = n_issue;
          if (q1.size() == 0) chk("p1_issue_unexpected", 1, 0);
          else begin
            chk("p1_addr", o_ctrl_addr, q1[0].addr);
            chk("p1_no_we", 32'(o_ctrl_we), 0);
          end
        end else if (q0.size() == 0) chk("p0_issue_unexpected", 1, 0);
        else begin
          chk("p0_addr", o_ctrl_addr, q0[0].addr);
          chk("p0_we", 32'(o_ctrl_we), 32'(q0[0].we));
          if (q0[0].we) chk("p0_wdata", o_ctrl_wdata, q0[0].wdata);
        end
      end
      prev_issue = issue; pv0 = i_p0_req; pv1 = i_p1_req;
    end
  end
  task automatic p0_txn(input logic we, input logic [31:0] a, input logic [31:0] d, output int cyc);
    txn_t t;
    t.we = we; t.addr = a; t.wdata = d;
    if (we) begin rmem[a] = d; t.rdata = last0; end
    else begin t.rdata = rd_ref(a); last0 = t.rdata; end
    q0.push_back(t);
    i_p0_req = 1; i_p0_we = we; i_p0_addr = a; i_p0_wdata = d;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (o_p0_ack) break;
      cyc++;
      if (cyc > 300) begin chk("p0_ack_timeout", 1, 0); break; end
    end
    @(posedge clk); #1;
    i_p0_req = 0;
  endtask
  task automatic p1_txn(input logic [31:0] a, output int cyc);
    txn_t t;
    t.we = 0; t.addr = a; t.wdata = 0; t.rdata = init_val(a); last1 = t.rdata;
    q1.push_back(t);
    i_p1_req = 1; i_p1_addr = a;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (o_p1_ack) break;
      cyc++;
      if (cyc > 300) begin chk("p1_ack_timeout", 1, 0); break; end
    end
    @(posedge clk); #1;
    i_p1_req = 0;
  endtask
  function automatic logic [31:0] p0_rand_addr();
    return 32'($urandom_range(0, 31)) << 2;
  endfunction
  function automatic logic [31:0] p1_rand_addr();
    return 32'h8000 | (32'($urandom_range(0, 255)) << 2);
  endfunction
  task automatic reset_zero_check(string tag);
    chk({tag, "_re"}, 32'(o_ctrl_re), 0);
    chk({tag, "_we"}, 32'(o_ctrl_we), 0);
    chk({tag, "_caddr"}, o_ctrl_addr, 0);
    chk({tag, "_cwdata"}, o_ctrl_wdata, 0);
    chk({tag, "_acks"}, 32'({o_p0_ack, o_p1_ack}), 0);
    chk({tag, "_stalls"}, 32'({o_p0_stall, o_p1_stall}), 0);
    chk({tag, "_rdata0"}, o_p0_rdata, 0);
    chk({tag, "_rdata1"}, o_p1_rdata, 0);
    chk({tag, "_err"}, 32'(o_err_tmo), 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end
  initial begin
    int c0, c1, base;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_zero_check("reset");
    @(posedge clk); #1;
    rst = 0;
    // read with a long busy period
    rmem[32'h40] = 32'hDEADBEEF; cmem[32'h40] = 32'hDEADBEEF;
    busy_n = 6;
    p0_txn(0, 32'h40, 32'h0, c0);
    chk("t1_latency", c0, 9);
    chk("t1_rdata", o_p0_rdata, 32'hDEADBEEF);
    // write leaves rdata alone
    busy_n = 2;
    p0_txn(1, 32'h80, 32'h12345678, c0);
    chk("t2_rdata_kept", o_p0_rdata, 32'hDEADBEEF);
    // simultaneous requests: P0 first
    fork
      p0_txn(0, 32'h44, 32'h0, c0);
      p1_txn(32'h8010, c1);
    join
    chk("t3_order", 32'(c1 > c0), 1);
    // P0 back-to-back while P1 waits: P1 lands on the 5th grant
    base = n_issue;
    fork
      begin
        int c;
        for (int i = 0; i < 6; i++) p0_txn(1'($urandom_range(0, 1)), p0_rand_addr(), $urandom, c);
      end
      p1_txn(32'h8020, c1);
    join
    chk("t4_p1_slot", p1_last_idx - base, 5);
    // controller never goes busy
    tmo_mode = 1;
    p0_txn(1, 32'h84, 32'hA5A5_0001, c0);
    chk("t5_latency", c0, 5);
    chk("t5_err", 32'(o_err_tmo), 1);
    tmo_mode = 0;
    p0_txn(0, 32'h84, 32'h0, c0);
    chk("t5_err_sticky", 32'(o_err_tmo), 1);
    // reset in WAIT_DONE aborts the transaction
    busy_n = 8;
    begin
      txn_t t;
      t.we = 0; t.addr = 32'h48; t.wdata = 0; t.rdata = rd_ref(32'h48);
      q0.push_back(t);
      i_p0_req = 1; i_p0_we = 0; i_p0_addr = 32'h48;
    end
    repeat (4) @(negedge clk);
    rst = 1;
    #1;
    q0.delete();
    last0 = 0; last1 = 0;
    reset_zero_check("t6");
    i_p0_req = 0;
    repeat (3) begin
      @(negedge clk);
      chk("t6_no_ack", 32'({o_p0_ack, o_p1_ack}), 0);
    end
    @(posedge clk); #1;
    rst = 0;
    p0_txn(0, 32'h40, 32'h0, c0);
    chk("t6_latency", c0, 11);
    chk("t6_rdata", o_p0_rdata, 32'hDEADBEEF);
    // random mixed traffic
    rand_busy = 1;
    fork
      for (int i = 0; i < 40; i++) begin
        int c, g;
        g = $urandom_range(0, 3);
        repeat (g) @(posedge clk);
        #1;
        p0_txn(1'($urandom_range(0, 1)), p0_rand_addr(), $urandom, c);
      end
      for (int j = 0; j < 40; j++) begin
        int c, g;
        g = $urandom_range(0, 3);
        repeat (g) @(posedge clk);
        #1;
        p1_txn(p1_rand_addr(), c);
      end
    join
    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
